// File: rtl/clint_pkg.sv
// Shared register offsets, bus FSM state type and reset constants for the core-local interruptor.
package clint_pkg;

  localparam logic [2:0] MSIP_OFF        = 3'd0;
  localparam logic [2:0] MTIMECMP_LO_OFF = 3'd1;
  localparam logic [2:0] MTIMECMP_HI_OFF = 3'd2;
  localparam logic [2:0] MTIME_LO_OFF    = 3'd3;
  localparam logic [2:0] MTIME_HI_OFF    = 3'd4;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {IDLE, ACCESS} bus_state_t;

  // Lane-wise merge used by every writable register.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaled 64-bit mtime counter; a write to either half beats the increment and restarts the prescaler.
// tick strobes in the cycle the counter advances (prescaler at PRESCALE-1).
module clint_mtime_counter #(
  parameter int PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_val,
  output logic [63:0] mtime,
  output logic        tick
);

  localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

  logic [7:0] ps_cnt;

  assign tick = (ps_cnt == PS_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps_cnt <= 8'd0;
      mtime  <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      ps_cnt <= 8'd0;
      if (wr_lo) mtime[31:0]  <= wr_val;
      if (wr_hi) mtime[63:32] <= wr_val;
    end else if (tick) begin
      ps_cnt <= 8'd0;
      mtime  <= mtime + 64'd1;
    end else begin
      ps_cnt <= ps_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/clint_timer_irq.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a one-wait-state 32-bit slave bus, plus irq levels.
// Define CLINT_EXT_SYNC_EN to pass ext_irq_in through a 2-flop synchronizer (otherwise it is a wire).
module clint_timer_irq
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic        ren,
  input  logic        wen,
  output logic        busy,
  output logic [31:0] rdata,
  input  logic        ext_irq_in,
  output logic [63:0] mtime,
  output logic        timer_int,
  output logic        soft_int,
  output logic        ext_int
);

  bus_state_t  state, state_nxt;
  logic        sel, req, commit, rd_en;
  logic [2:0]  off;
  logic        wr_any, wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mt_lo, wr_mt_hi;
  logic [31:0] mt_wr_val;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow;
  logic        msip;
  logic        mtime_tick_unused;
  logic        addr_lsb_unused;

  assign sel             = (addr[31:5] == BASE_ADDR[31:5]);
  assign req             = (ren | wen) & sel;
  assign off             = addr[4:2];
  assign addr_lsb_unused = ^addr[1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write wins when both strobes are held, so a combined request never drives read data.
  always_comb begin
    busy   = 1'b0;
    commit = 1'b0;
    rd_en  = 1'b0;
    case (state)
      IDLE:   busy = req;
      ACCESS: begin
        commit = wen & sel;
        rd_en  = ren & ~wen & sel;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    if (rd_en) begin
      case (off)
        MSIP_OFF:        rdata = {31'd0, msip};
        MTIMECMP_LO_OFF: rdata = mtimecmp[31:0];
        MTIMECMP_HI_OFF: rdata = mtimecmp[63:32];
        MTIME_LO_OFF:    rdata = mtime[31:0];
        MTIME_HI_OFF:    rdata = hi_shadow;
        default:         rdata = 32'd0;
      endcase
    end
  end

  assign wr_any    = commit & (|byte_en);
  assign wr_msip   = wr_any & (off == MSIP_OFF) & byte_en[0];
  assign wr_cmp_lo = wr_any & (off == MTIMECMP_LO_OFF);
  assign wr_cmp_hi = wr_any & (off == MTIMECMP_HI_OFF);
  assign wr_mt_lo  = wr_any & (off == MTIME_LO_OFF);
  assign wr_mt_hi  = wr_any & (off == MTIME_HI_OFF);
  assign mt_wr_val = merge_bytes(wr_mt_hi ? mtime[63:32] : mtime[31:0], wdata, byte_en);

  clint_mtime_counter #(.PRESCALE(PRESCALE)) u_mtime (
    .CLK    (CLK),
    .RST    (RST),
    .wr_lo  (wr_mt_lo),
    .wr_hi  (wr_mt_hi),
    .wr_val (mt_wr_val),
    .mtime  (mtime),
    .tick   (mtime_tick_unused)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mtimecmp  <= MTIMECMP_RESET;
      msip      <= 1'b0;
      hi_shadow <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wdata, byte_en);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, byte_en);
      if (wr_msip)   msip <= wdata[0];
      // Snapshot hi alongside the lo read so a later hi read pairs with it across a carry.
      if (rd_en && (off == MTIME_LO_OFF)) hi_shadow <= mtime[63:32];
      timer_int <= (mtime >= mtimecmp);
    end
  end

  assign soft_int = msip;

`ifdef CLINT_EXT_SYNC_EN
  logic [1:0] ext_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ext_sync <= 2'b00;
    else     ext_sync <= {ext_sync[0], ext_irq_in};
  end

  assign ext_int = ext_sync[1];
`else
  assign ext_int = ext_irq_in;
`endif

endmodule

// File: tb/tb_clint_timer_irq.sv
// Directed bench for clint_timer_irq: reads go through an expected-data queue drained by a bus monitor.
module tb_clint_timer_irq;

  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef CLINT_EXT_SYNC_EN
  localparam int EXT_LAT = 2;
`else
  localparam int EXT_LAT = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  byte_en = 4'd0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic        busy;
  logic [31:0] rdata;
  logic        ext_irq_in = 1'b0;
  logic [63:0] mtime;
  logic        timer_int;
  logic        soft_int;
  logic        ext_int;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  bit          rd_pending = 1'b0;

  clint_timer_irq #(.BASE_ADDR(32'h8000_0000), .PRESCALE(1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .addr       (addr),
    .wdata      (wdata),
    .byte_en    (byte_en),
    .ren        (ren),
    .wen        (wen),
    .busy       (busy),
    .rdata      (rdata),
    .ext_irq_in (ext_irq_in),
    .mtime      (mtime),
    .timer_int  (timer_int),
    .soft_int   (soft_int),
    .ext_int    (ext_int)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the closing edge.
  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_rd, input int exp_wait,
                     input string nm);
    int wait_cyc;
    if (r) begin
      exp_q.push_back(exp_rd);
      nm_q.push_back(nm);
      rd_pending = 1'b1;
    end
    addr = a; wdata = d; byte_en = be; ren = r; wen = w;
    wait_cyc = 0;
    @(negedge CLK);
    while (busy !== 1'b0 && wait_cyc < 20) begin
      wait_cyc++;
      @(negedge CLK);
    end
    chk({nm, "_busy_cycles"}, 64'(wait_cyc), 64'(exp_wait));
    @(posedge CLK);
    #1;
    ren = 1'b0; wen = 1'b0; rd_pending = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] be,
                    input string nm);
    bus(1'b0, 1'b1, BASE | {27'd0, off, 2'b00}, d, be, 32'd0, 1, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input int exp_wait,
                    input string nm);
    bus(1'b1, 1'b0, a, 32'd0, 4'hF, exp, exp_wait, nm);
  endtask

  // Monitor: a read completes on the negedge where busy is low with a read outstanding.
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge CLK);
      if (rd_pending && busy === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_read", 64'(rdata), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          n = nm_q.pop_front();
          chk(n, 64'(rdata), 64'(e));
        end
      end
    end
  end

  initial begin
    bit hit;

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_timer", 64'(timer_int), 64'd0);
    chk("rst_soft", 64'(soft_int), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);

    repeat (10) @(posedge CLK);
    #1;
    chk("mtime_10", mtime, 64'd10);
    chk("idle_timer", 64'(timer_int), 64'd0);
    chk("idle_soft", 64'(soft_int), 64'd0);

    // Compare at 20: level must trail mtime reaching 20 by one cycle.
    wr(3'd1, 32'd20, 4'hF, "wr_cmp_lo");
    wr(3'd2, 32'd0, 4'hF, "wr_cmp_hi");
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge CLK);
      if (mtime == 64'd20) hit = 1'b1;
    end
    chk("timer_reach_20", 64'(hit), 64'd1);
    chk("timer_at_20", 64'(timer_int), 64'd0);
    @(negedge CLK);
    chk("timer_rise", 64'(timer_int), 64'd1);
    repeat (3) @(negedge CLK);
    chk("timer_hold", 64'(timer_int), 64'd1);
    @(posedge CLK);
    #1;
    wr(3'd2, 32'd1, 4'hF, "wr_cmp_hi1");
    chk("timer_commit_edge", 64'(timer_int), 64'd1);
    @(posedge CLK);
    #1;
    chk("timer_fall", 64'(timer_int), 64'd0);

    // mtime = 0x0_FFFFFFFF; the lo increment carries before hi=0 lands.
    wr(3'd3, 32'hFFFF_FFFF, 4'hF, "wr_mt_lo");
    wr(3'd4, 32'd0, 4'hF, "wr_mt_hi");
    rd(BASE | 32'h0C, 32'd1, 1, "rd_mt_lo_a");
    rd(BASE | 32'h10, 32'd0, 1, "rd_mt_hi_a");
    // Lo read just before the carry: hi must come from the shadow, not live.
    wr(3'd4, 32'd0, 4'hF, "wr_mt_hi_b");
    wr(3'd3, 32'hFFFF_FFFD, 4'hF, "wr_mt_lo_b");
    rd(BASE | 32'h0C, 32'hFFFF_FFFE, 1, "rd_mt_lo_b");
    rd(BASE | 32'h10, 32'd0, 1, "rd_mt_hi_b");
    chk("mtime_after_carry", mtime, 64'h0000_0001_0000_0001);

    // msip and byte enables.
    wr(3'd0, 32'd1, 4'b0000, "wr_msip_be0");
    chk("soft_be0", 64'(soft_int), 64'd0);
    wr(3'd0, 32'd1, 4'b0001, "wr_msip_be1");
    chk("soft_set", 64'(soft_int), 64'd1);
    rd(BASE, 32'd1, 1, "rd_msip");
    wr(3'd1, 32'hAABB_CCDD, 4'b0101, "wr_cmp_lo_partial");
    rd(BASE | 32'h04, 32'h00BB_00DD, 1, "rd_cmp_lo_partial");

    // Unmapped, non-matching, and combined read+write.
    rd(BASE | 32'h18, 32'd0, 1, "rd_unmapped");
    rd(32'h4000_0000, 32'd0, 0, "rd_nomatch");
    rd(BASE | 32'h20, 32'd0, 0, "rd_nomatch_a5");
    bus(1'b1, 1'b1, BASE, 32'd0, 4'b0001, 32'd0, 1, "rdwr_msip");
    chk("soft_cleared", 64'(soft_int), 64'd0);

    // Reset in the middle of a mtimecmp write.
    wr(3'd0, 32'd1, 4'b0001, "wr_msip_pre_rst");
    addr = BASE | 32'h04; wdata = 32'd5; byte_en = 4'hF; wen = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("access_busy", 64'(busy), 64'd0);
    #1;
    RST = 1'b1; wen = 1'b0;
    #1;
    chk("midrst_mtime", mtime, 64'd0);
    chk("midrst_soft", 64'(soft_int), 64'd0);
    chk("midrst_timer", 64'(timer_int), 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    rd(BASE | 32'h04, 32'hFFFF_FFFF, 1, "rd_cmp_lo_rst");
    rd(BASE | 32'h08, 32'hFFFF_FFFF, 1, "rd_cmp_hi_rst");

    // External interrupt latency, rising then falling.
    ext_irq_in = 1'b1;
    #1;
    chk("ext_rise_0", 64'(ext_int), 64'(0 >= EXT_LAT));
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("ext_rise_%0d", k), 64'(ext_int), 64'(k >= EXT_LAT));
    end
    ext_irq_in = 1'b0;
    #1;
    chk("ext_fall_0", 64'(ext_int), 64'(0 < EXT_LAT));
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("ext_fall_%0d", k), 64'(ext_int), 64'(k < EXT_LAT));
    end

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
